// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared types and constants for the pattern-select path that feeds the
// HEX4/HEX5 pattern-count display and the Life board pattern ROM.
//   PAT_W        width of a pattern index (display and ROM address use it too)
//   sel_state_t  load-handshake FSM states of pattern_select_counter
//   wrap_step()  one up/down step of the pattern index with wrap-around
// ---------------------------------------------------------------------------
package life_pkg;

    localparam int PAT_W = 4;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_REQ,
        SEL_WAIT
    } sel_state_t;

    // Step the index by one in either direction, wrapping inside 0..num-1.
    function automatic logic [PAT_W-1:0] wrap_step(
        input logic [PAT_W-1:0] cur,
        input logic             up,
        input int unsigned      num
    );
        logic [PAT_W-1:0] last;
        last = PAT_W'(num - 1);
        if (up) begin
            return (cur == last) ? '0 : cur + PAT_W'(1);
        end
        return (cur == '0) ? last : cur - PAT_W'(1);
    endfunction

endpackage

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
// Turns one raw active-low push button into a one-cycle step pulse:
// synchroniser, press-edge detect and a hold-to-repeat timer.
//   clk         system clock
//   reset       synchronous, active-low
//   key_n       raw button, active-low, asynchronous to clk
//   other_held  the other button is currently held (suppresses auto-repeat)
//   held        this button is held (synchronised, active-high)
//   step        registered one-cycle pulse per press or repeat tick
// ---------------------------------------------------------------------------
module key_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REPEAT_DLY  = 25,
    parameter int unsigned REPEAT_RATE = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic other_held,
    output logic held,
    output logic step
);

    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1) + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_n_q, last_n_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   repeating_q, repeating_d;
    logic                   step_q, step_d;

    logic level;
    logic press;
    logic alone;
    logic repeat_hit;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], key_n};
        level    = ~sync_q[SYNC_STAGES-1];
        // Previous synced raw level; "released" (1) means this cycle's 1 is a new press.
        last_n_d = sync_q[SYNC_STAGES-1];
        press    = level & last_n_q;
        alone    = level & ~other_held;

        // Hold timer: counts held cycles while this key alone is down. The first
        // tick waits REPEAT_DLY, later ticks REPEAT_RATE; any release or a
        // both-keys chord clears it.
        cnt_d       = '0;
        repeating_d = 1'b0;
        repeat_hit  = 1'b0;
        if ((REPEAT_DLY > 0) && alone) begin
            if (repeating_q ? (cnt_q == CNT_W'(REPEAT_RATE)) : (cnt_q == CNT_W'(REPEAT_DLY))) begin
                repeat_hit  = 1'b1;
                cnt_d       = CNT_W'(1);
                repeating_d = 1'b1;
            end else begin
                cnt_d       = cnt_q + CNT_W'(1);
                repeating_d = repeating_q;
            end
        end

        step_d = press | repeat_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q      <= '1;
            last_n_q    <= 1'b1;
            cnt_q       <= '0;
            repeating_q <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            last_n_q    <= last_n_d;
            cnt_q       <= cnt_d;
            repeating_q <= repeating_d;
            step_q      <= step_d;
        end
    end

    assign held = level;
    assign step = step_q;

endmodule

// File: rtl/pattern_select_counter.sv
// ---------------------------------------------------------------------------
// pattern_select_counter
// Selects a Life pattern index from the next/prev keys and asks the board to
// load it through a req/ack handshake. Key steps are ignored while a load is
// in flight (they are dropped, not queued).
//   clk            system clock
//   reset          synchronous, active-low
//   key_next_n     raw KEY, active-low; press = next pattern
//   key_prev_n     raw KEY, active-low; press = previous pattern
//   load_ack       one-cycle pulse: board has latched pattern_count
//   pattern_count  registered pattern index 0..NUM_PATTERNS-1
//   load_req       high from the request until load_ack
//   busy           high while a load handshake is in progress
// ---------------------------------------------------------------------------
module pattern_select_counter
    import life_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS = 10,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned REPEAT_DLY   = 25,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_next_n,
    input  logic             key_prev_n,
    input  logic             load_ack,
    output logic [PAT_W-1:0] pattern_count,
    output logic             load_req,
    output logic             busy
);

    logic step_next, step_prev;
    logic held_next, held_prev;

    key_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_key_next (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_next_n),
        .other_held (held_prev),
        .held       (held_next),
        .step       (step_next)
    );

    key_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_key_prev (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_prev_n),
        .other_held (held_next),
        .held       (held_prev),
        .step       (step_prev)
    );

    sel_state_t       state_q, state_d;
    logic [PAT_W-1:0] count_q, count_d;
    logic             load_req_q, load_req_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        load_req_d = load_req_q;
        busy_d     = busy_q;
        case (state_q)
            SEL_IDLE: begin
                // A chord (both steps together) is treated as no input.
                if (step_next ^ step_prev) begin
                    count_d = wrap_step(count_q, step_next, NUM_PATTERNS);
                    busy_d  = 1'b1;
                    state_d = SEL_REQ;
                end
            end
            SEL_REQ: begin
                // One cycle after the count update, so the board never sees
                // load_req with a count that is still changing.
                load_req_d = 1'b1;
                state_d    = SEL_WAIT;
            end
            SEL_WAIT: begin
                if (load_ack) begin
                    load_req_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = SEL_IDLE;
                end
            end
            default: begin
                load_req_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = SEL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= SEL_IDLE;
            count_q    <= '0;
            load_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            load_req_q <= load_req_d;
            busy_q     <= busy_d;
        end
    end

    assign pattern_count = count_q;
    assign load_req      = load_req_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_pattern_select_counter.sv
// ---------------------------------------------------------------------------
// tb_pattern_select_counter
// Self-checking bench for pattern_select_counter. Expected pattern indices come
// from modular arithmetic on the key presses; expected auto-repeat instants come
// from the hold-delay / repeat-rate schedule.
// ---------------------------------------------------------------------------
module tb_pattern_select_counter;

    localparam int N    = 10;
    localparam int SYNC = 2;
    localparam int DLY  = 25;
    localparam int RATE = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_next_n;
    logic       key_prev_n;
    logic       load_ack;
    logic [3:0] pattern_count;
    logic       load_req;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int req_rises   = 0;
    int chg_cyc[$];
    int exp_count   = 0;

    bit ack_auto      = 1'b0;
    int ack_delay     = 0;
    int manual_acks   = 0;
    int manual_served = 0;

    pattern_select_counter #(
        .NUM_PATTERNS (N),
        .SYNC_STAGES  (SYNC),
        .REPEAT_DLY   (DLY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_next_n    (key_next_n),
        .key_prev_n    (key_prev_n),
        .load_ack      (load_ack),
        .pattern_count (pattern_count),
        .load_req      (load_req),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: load_req rising edges and the posedge index of every count change.
    initial begin
        logic [3:0] last_count;
        logic       last_req;
        last_count = 4'd0;
        last_req   = 1'b0;
        forever begin
            @(negedge clk);
            if (load_req === 1'b1 && last_req !== 1'b1) req_rises++;
            if (pattern_count !== last_count) chg_cyc.push_back(cyc);
            last_count = pattern_count;
            last_req   = load_req;
        end
    end

    // Board model: acknowledges requests automatically after ack_delay cycles,
    // or issues one pulse per manual request.
    initial begin
        load_ack = 1'b0;
        forever begin
            @(negedge clk);
            load_ack = 1'b0;
            if (manual_served != manual_acks) begin
                load_ack = 1'b1;
                manual_served++;
            end else if (ack_auto && load_req === 1'b1) begin
                repeat (ack_delay) @(negedge clk);
                load_ack = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_step(input int cur, input bit up);
        return up ? (cur + 1) % N : (cur + N - 1) % N;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        reset      = 1'b1;
        @(negedge clk);
        chg_cyc.delete();
        req_rises = 0;
        exp_count = 0;
    endtask

    task automatic press(input bit is_next, input int hold);
        if (is_next) key_next_n = 1'b0;
        else         key_prev_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (SYNC + 4) @(negedge clk);
        while ((busy !== 1'b0 || load_req !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            $display("FAIL wait_idle timeout: busy=%b load_req=%b required 0/0", busy, load_req);
            miscompares++;
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (load_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 50) begin
            $display("FAIL wait_req timeout: load_req=%b required 1", load_req);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        int bad;
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (pattern_count !== 4'd0 || load_req !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_values: count=%0d load_req=%b busy=%b required 0/0/0",
                     pattern_count, load_req, busy);
            miscompares++;
        end
        reset = 1'b1;
        req_rises = 0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pattern_count !== 4'd0 || load_req !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL reset_idle_hold: %0d disturbed cycles, required 0", bad);
            miscompares++;
        end
        vectors++;
        if (req_rises != 0) begin
            $display("FAIL reset_no_req: %0d requests, required 0", req_rises);
            miscompares++;
        end
        $display("reset: idle for 100 cycles, count=%0d", pattern_count);
    endtask

    task automatic test_next_steps();
        int old_count;
        int rises0;
        ack_auto  = 1'b1;
        ack_delay = 2;
        rises0    = req_rises;
        for (int i = 0; i < 3; i++) begin
            old_count  = exp_count;
            exp_count  = model_step(exp_count, 1'b1);
            key_next_n = 1'b0;
            repeat (SYNC + 1) @(negedge clk);
            vectors++;
            if (int'(pattern_count) !== old_count) begin
                $display("FAIL latency_early: count=%0d required %0d", pattern_count, old_count);
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if (int'(pattern_count) !== exp_count || busy !== 1'b1 || load_req !== 1'b0) begin
                $display("FAIL step_update: count=%0d busy=%b load_req=%b required %0d/1/0",
                         pattern_count, busy, load_req, exp_count);
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if (load_req !== 1'b1) begin
                $display("FAIL req_rise: load_req=%b required 1", load_req);
                miscompares++;
            end
            key_next_n = 1'b1;
            wait_idle();
            $display("next press %0d: count=%0d", i, pattern_count);
        end
        vectors++;
        if (req_rises - rises0 != 3 || int'(pattern_count) !== exp_count) begin
            $display("FAIL next_x3: requests=%0d count=%0d required 3/%0d",
                     req_rises - rises0, pattern_count, exp_count);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ack_auto  = 1'b1;
        ack_delay = 1;
        press(1'b0, 3);
        wait_idle();
        exp_count = model_step(exp_count, 1'b0);
        vectors++;
        if (int'(pattern_count) !== exp_count) begin
            $display("FAIL wrap_down: count=%0d required %0d", pattern_count, exp_count);
            miscompares++;
        end
        press(1'b1, 3);
        wait_idle();
        exp_count = model_step(exp_count, 1'b1);
        vectors++;
        if (int'(pattern_count) !== exp_count) begin
            $display("FAIL wrap_up: count=%0d required %0d", pattern_count, exp_count);
            miscompares++;
        end
        $display("wrap: prev then next, count=%0d", pattern_count);
    endtask

    task automatic test_drop_during_wait();
        do_reset();
        ack_auto = 1'b0;
        press(1'b1, 2);
        wait_req();
        exp_count = model_step(exp_count, 1'b1);
        repeat (10) @(negedge clk);
        press(1'b1, 3);
        repeat (5) @(negedge clk);
        press(1'b0, 3);
        repeat (30) @(negedge clk);
        vectors++;
        if (int'(pattern_count) !== exp_count || load_req !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL drop_in_wait: count=%0d load_req=%b busy=%b required %0d/1/1",
                     pattern_count, load_req, busy, exp_count);
            miscompares++;
        end
        manual_acks++;
        wait (load_ack === 1'b1);
        @(negedge clk);
        vectors++;
        if (load_req !== 1'b0 || busy !== 1'b0 || int'(pattern_count) !== exp_count) begin
            $display("FAIL ack_release: load_req=%b busy=%b count=%0d required 0/0/%0d",
                     load_req, busy, pattern_count, exp_count);
            miscompares++;
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (int'(pattern_count) !== exp_count || req_rises != 1) begin
            $display("FAIL no_queued_step: count=%0d requests=%0d required %0d/1",
                     pattern_count, req_rises, exp_count);
            miscompares++;
        end
        // A stray ack in IDLE must not be remembered for the next request.
        manual_acks++;
        wait (load_ack === 1'b1);
        repeat (3) @(negedge clk);
        press(1'b1, 2);
        wait_req();
        exp_count = model_step(exp_count, 1'b1);
        repeat (5) @(negedge clk);
        vectors++;
        if (load_req !== 1'b1 || int'(pattern_count) !== exp_count) begin
            $display("FAIL idle_ack_ignored: load_req=%b count=%0d required 1/%0d",
                     load_req, pattern_count, exp_count);
            miscompares++;
        end
        manual_acks++;
        wait_idle();
        $display("drop during wait: count=%0d", pattern_count);
    endtask

    task automatic test_repeat();
        int t0;
        int exp_t;
        int rises0;
        int count0;
        do_reset();
        ack_auto  = 1'b1;
        ack_delay = 0;
        chg_cyc.delete();
        t0 = cyc + 1;
        key_next_n = 1'b0;
        repeat (60) @(negedge clk);
        key_next_n = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if (chg_cyc.size() != 5) begin
            $display("FAIL repeat_steps: %0d steps required 5", chg_cyc.size());
            miscompares++;
        end
        for (int i = 0; i < 5 && i < chg_cyc.size(); i++) begin
            exp_t = t0 + SYNC + 1 + ((i == 0) ? 0 : DLY + (i - 1) * RATE);
            vectors++;
            if (chg_cyc[i] != exp_t) begin
                $display("FAIL repeat_time%0d: step at +%0d required +%0d", i, chg_cyc[i] - t0, exp_t - t0);
                miscompares++;
            end
        end
        for (int i = 0; i < 5; i++) exp_count = model_step(exp_count, 1'b1);
        vectors++;
        if (int'(pattern_count) !== exp_count) begin
            $display("FAIL repeat_count: count=%0d required %0d", pattern_count, exp_count);
            miscompares++;
        end
        $display("hold next 60 cycles: %0d steps, count=%0d", chg_cyc.size(), pattern_count);

        chg_cyc.delete();
        rises0 = req_rises;
        count0 = exp_count;
        key_next_n = 1'b0;
        key_prev_n = 1'b0;
        repeat (40) @(negedge clk);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (chg_cyc.size() != 0 || req_rises != rises0 || int'(pattern_count) !== count0) begin
            $display("FAIL chord_no_step: steps=%0d requests=%0d count=%0d required 0/0/%0d",
                     chg_cyc.size(), req_rises - rises0, pattern_count, count0);
            miscompares++;
        end
        $display("chord next+prev held 40 cycles: count=%0d", pattern_count);
    endtask

    task automatic test_reset_mid();
        int rises0;
        ack_auto = 1'b0;
        press(1'b1, 2);
        wait_req();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (load_req !== 1'b0 || pattern_count !== 4'd0 || busy !== 1'b0) begin
            $display("FAIL reset_mid: load_req=%b count=%0d busy=%b required 0/0/0",
                     load_req, pattern_count, busy);
            miscompares++;
        end
        reset     = 1'b1;
        exp_count = 0;
        rises0    = req_rises;
        manual_acks++;
        repeat (20) @(negedge clk);
        vectors++;
        if (load_req !== 1'b0 || busy !== 1'b0 || pattern_count !== 4'd0 || req_rises != rises0) begin
            $display("FAIL late_ack: load_req=%b busy=%b count=%0d requests=%0d required 0/0/0/0",
                     load_req, busy, pattern_count, req_rises - rises0);
            miscompares++;
        end
        $display("reset during wait: count=%0d load_req=%b", pattern_count, load_req);
    endtask

    task automatic test_random();
        bit up;
        int hold;
        int rises0;
        do_reset();
        ack_auto = 1'b1;
        rises0   = req_rises;
        for (int i = 0; i < 20; i++) begin
            up        = 1'($urandom_range(0, 1));
            hold      = int'($urandom_range(1, 15));
            ack_delay = int'($urandom_range(0, 5));
            press(up, hold);
            wait_idle();
            exp_count = model_step(exp_count, up);
            vectors++;
            if (int'(pattern_count) !== exp_count) begin
                $display("FAIL random_count%0d: count=%0d required %0d", i, pattern_count, exp_count);
                miscompares++;
            end
            $display("random %0d: %s hold=%0d ack_delay=%0d count=%0d",
                     i, up ? "next" : "prev", hold, ack_delay, pattern_count);
        end
        vectors++;
        if (req_rises - rises0 != 20) begin
            $display("FAIL random_requests: %0d requests required 20", req_rises - rises0);
            miscompares++;
        end
    endtask

    initial begin
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        reset      = 1'b0;
        test_reset();
        test_next_steps();
        test_wrap();
        test_drop_during_wait();
        test_repeat();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
